// File: rtl/rr_exe_issue_queue_pkg.sv
// Shared types for the rr->exe issue queue slice: the packet format carried
// from read-register to the execute stage and the default queue depth.
package rr_exe_issue_queue_pkg;

  localparam int ISSUE_Q_DEPTH = 4;

  typedef enum logic [2:0] {
    INSTR_NOP    = 3'd0,
    INSTR_ADD    = 3'd1,
    INSTR_MUL    = 3'd2,
    INSTR_LOAD   = 3'd3,
    INSTR_BRANCH = 3'd4
  } instr_type_t;

  typedef struct packed {
    logic        valid;
    logic [39:0] pc;
    instr_type_t instr_type;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } instr_entry_t;

  typedef struct packed {
    instr_entry_t instr;
    logic [63:0]  data_rs1;
    logic [63:0]  data_rs2;
    logic         rdy1;
    logic         rdy2;
  } rr_exe_instr_t;

endpackage

// File: rtl/rr_exe_issue_queue_if.sv
// Handshake bundle between read-register (producer), the issue queue and the
// execute stage. The master side is the pipeline around the queue; the slave
// side is the queue itself.
interface rr_exe_issue_queue_if;
  import rr_exe_issue_queue_pkg::*;

  logic          in_valid;
  rr_exe_instr_t in_instr;
  logic          in_ready;
  rr_exe_instr_t from_rr;
  logic          exe_stall;

  modport master (
    output in_valid,
    output in_instr,
    output exe_stall,
    input  in_ready,
    input  from_rr
  );

  modport slave (
    input  in_valid,
    input  in_instr,
    input  exe_stall,
    output in_ready,
    output from_rr
  );

endinterface

// File: rtl/rr_exe_issue_queue_fifo.sv
// Circular buffer holding issue packets: storage, read/write pointers and an
// explicit occupancy count. A flush returns it to empty without clearing data.
module rr_exe_issue_queue_fifo
  import rr_exe_issue_queue_pkg::*;
#(
  parameter int DEPTH = ISSUE_Q_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  rr_exe_instr_t            push_data_i,
  output rr_exe_instr_t            head_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  rr_exe_instr_t entry_q [DEPTH];
  rr_exe_instr_t entry_d [DEPTH];
  ptr_t          rd_ptr_q, rd_ptr_d;
  ptr_t          wr_ptr_q, wr_ptr_d;
  cnt_t          count_q,  count_d;

  // Next-state for pointers, count and storage; flush overrides everything.
  always_comb begin
    entry_d  = entry_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        entry_d[wr_ptr_q] = push_data_i;
        wr_ptr_d          = ptr_t'(wr_ptr_q + 1'b1);
      end
      if (pop_i) begin
        rd_ptr_d = ptr_t'(rd_ptr_q + 1'b1);
      end
      count_d = cnt_t'(count_q + cnt_t'(push_i) - cnt_t'(pop_i));
    end
  end

  // Control state is reset; packet storage is left as-is to keep it cheap.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage register, written only through entry_d.
  always_ff @(posedge clk_i) begin
    entry_q <= entry_d;
  end

  // Head is forced to zero when empty so exe never sees a stale packet.
  always_comb begin
    head_o = '0;
    if (count_q != '0) begin
      head_o = entry_q[rd_ptr_q];
    end
  end

  assign occupancy_o = count_q;
  assign full_o      = (count_q == cnt_t'(DEPTH));

endmodule

// File: rtl/rr_exe_issue_queue.sv
// Producer end of the rr->exe interface. Buffers packets from read-register,
// holds the head stable while exe stalls, flushes on kill and counts stall
// cycles for the PMU.
module rr_exe_issue_queue
  import rr_exe_issue_queue_pkg::*;
#(
  parameter int DEPTH = ISSUE_Q_DEPTH,
  parameter int CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   kill_i,
  rr_exe_issue_queue_if.slave    bus,
  output logic [$clog2(DEPTH):0] occupancy_o,
  output logic                   full_o,
  output logic                   pmu_issue_stall_o,
  output logic [CNT_W-1:0]       stall_cycles_o
);

  rr_exe_instr_t    head;
  logic             head_valid;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  rr_exe_issue_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .flush_i     (kill_i),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (bus.in_instr),
    .head_o      (head),
    .occupancy_o (occupancy_o),
    .full_o      (full_o)
  );

  // Handshake: a pop frees a slot in the same cycle, so ready only drops
  // when full and exe is stalled. The stall->ready path is combinational.
  always_comb begin
    head_valid        = head.instr.valid;
    bus.in_ready      = !full_o || !bus.exe_stall;
    push              = bus.in_valid && bus.in_ready && !kill_i;
    pop               = head_valid && !bus.exe_stall && !kill_i;
    pmu_issue_stall_o = head_valid && bus.exe_stall && !kill_i;
    bus.from_rr       = head;
  end

  // Saturating stall-cycle counter; survives kill, cleared only by reset.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pmu_issue_stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;

endmodule
